rx_prbs_checker: RTL



---
 rtl/rx_prbs_checker_pkg.sv | 26 ++
 rtl/rx_chk_window.sv | 51 +++++
 rtl/rx_prbs_checker.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rx_prbs_checker_pkg.sv
// ============================================================================
// Module   : rx_prbs_checker_pkg
// Brief    : Shared constants and types for the RX PRBS checker and TX PRBS
//            generator (one source of truth for the default polynomial).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rx_prbs_checker_pkg;

    localparam int FILTER_OUT_WIDTH = 16;
    localparam int RX_CHK_CNT_WIDTH = 32;

    // Default polynomial x^7 + x^6 + 1, taps are 1-based
    localparam int PRBS_POLY_N     = 7;
    localparam int PRBS_POLY_TAP_A = 7;
    localparam int PRBS_POLY_TAP_B = 6;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } RX_CHK_STATE;

endpackage

`default_nettype wire

// File: rtl/rx_chk_window.sv
// ============================================================================
// Module   : rx_chk_window
// Brief    : Fixed-length error window used to decide loss of PRBS lock.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_chk_window #(
    parameter int LOCK_COUNT  = 64,
    parameter int UNLOCK_ERRS = 8
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic i_restart,
    input  logic i_bit_en,
    input  logic i_err,
    output logic window_done,
    output logic window_fail
);

    localparam int WCW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam int WEW = $clog2(LOCK_COUNT + 1);
    localparam logic [WCW-1:0] c_win_last = WCW'(LOCK_COUNT - 1);

    logic [WCW-1:0] r_win_cnt;
    logic [WEW-1:0] r_win_err;
    logic [WEW:0]   w_err_total;

    // The bit closing the window is included in the unlock decision
    assign w_err_total = {1'b0, r_win_err} + {{WEW{1'b0}}, i_err};
    assign window_done = i_bit_en && (r_win_cnt == c_win_last);
    assign window_fail = window_done && (32'(w_err_total) >= 32'(UNLOCK_ERRS));

    always_ff @(posedge clk_sys) begin
        if (rst || i_restart) begin
            r_win_cnt <= '0;
            r_win_err <= '0;
        end else if (i_bit_en) begin
            if (window_done) begin
                r_win_cnt <= '0;
                r_win_err <= '0;
            end else begin
                r_win_cnt <= r_win_cnt + WCW'(1);
                r_win_err <= w_err_total[WEW-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rx_prbs_checker.sv
// ============================================================================
// Module   : rx_prbs_checker
// Brief    : Self-synchronising receive PRBS checker with bit/error counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_prbs_checker
    import rx_prbs_checker_pkg::*;
#(
    parameter int SIG_WIDTH   = FILTER_OUT_WIDTH,
    parameter int PRBS_N      = PRBS_POLY_N,
    parameter int TAP_A       = PRBS_POLY_TAP_A,
    parameter int TAP_B       = PRBS_POLY_TAP_B,
    parameter int LOCK_COUNT  = 64,
    parameter int UNLOCK_ERRS = 8,
    parameter int CNT_WIDTH   = RX_CHK_CNT_WIDTH
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic                 cke_rx,
    input  logic [SIG_WIDTH-1:0] sig_rx,
    input  logic                 clear_cnt,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic                 err_flag,
    output logic                 locked,
    output logic [CNT_WIDTH-1:0] bit_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int MCW = $clog2(LOCK_COUNT + 1);
    localparam logic [MCW-1:0] c_lock_cnt = MCW'(LOCK_COUNT);

    RX_CHK_STATE          r_state;
    logic [PRBS_N-1:0]    r_sreg;
    logic [MCW-1:0]       r_match;
    logic                 r_bit_out;
    logic                 r_bit_valid;
    logic                 r_err_flag;
    logic [CNT_WIDTH-1:0] r_bit_count;
    logic [CNT_WIDTH-1:0] r_err_count;

    logic           w_b;
    logic           w_p;
    logic           w_err;
    logic           w_bit_en;
    logic [MCW-1:0] w_match_next;
    logic           w_window_done;
    logic           w_window_fail;

    // Zero slices to one, so a signed compare against zero covers the boundary
    assign w_b   = ($signed(sig_rx) >= $signed({SIG_WIDTH{1'b0}}));
    assign w_p   = r_sreg[TAP_A-1] ^ r_sreg[TAP_B-1];
    assign w_err = w_b ^ w_p;

    // An all-zero register is the illegal LFSR state and never counts as a match
    assign w_match_next = ((r_sreg != '0) && !w_err) ? (r_match + MCW'(1)) : '0;
    assign w_bit_en     = cke_rx && (r_state == LOCKED);

    rx_chk_window #(
        .LOCK_COUNT  (LOCK_COUNT),
        .UNLOCK_ERRS (UNLOCK_ERRS)
    ) u_window (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .i_restart   (r_state == SEARCH),
        .i_bit_en    (w_bit_en),
        .i_err       (w_err),
        .window_done (w_window_done),
        .window_fail (w_window_fail)
    );

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state     <= SEARCH;
            r_sreg      <= '0;
            r_match     <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_err_flag  <= 1'b0;
        end else begin
            r_bit_valid <= cke_rx;
            r_err_flag  <= 1'b0;
            if (cke_rx) begin
                r_bit_out <= w_b;
                case (r_state)
                    SEARCH: begin
                        r_sreg <= {r_sreg[PRBS_N-2:0], w_b};
                        if (w_match_next == c_lock_cnt) begin
                            r_state <= LOCKED;
                            r_match <= '0;
                        end else begin
                            r_match <= w_match_next;
                        end
                    end
                    LOCKED: begin
                        // Reference free-runs so a channel error never propagates
                        r_sreg     <= {r_sreg[PRBS_N-2:0], w_p};
                        r_err_flag <= w_err;
                        if (w_window_fail) begin
                            r_state <= SEARCH;
                            r_match <= '0;
                        end
                    end
                    default: begin
                        r_state <= SEARCH;
                        r_match <= '0;
                    end
                endcase
            end
        end
    end

    // Counters survive loss of lock; only reset or an explicit clear zeroes them
    always_ff @(posedge clk_sys) begin
        if (rst || clear_cnt) begin
            r_bit_count <= '0;
            r_err_count <= '0;
        end else if (w_bit_en) begin
            if (r_bit_count != '1) begin
                r_bit_count <= r_bit_count + CNT_WIDTH'(1);
            end
            if (w_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + CNT_WIDTH'(1);
            end
        end
    end

    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign err_flag  = r_err_flag;
    assign locked    = (r_state == LOCKED);
    assign bit_count = r_bit_count;
    assign err_count = r_err_count;

endmodule

`default_nettype wire
